memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 213 +++++++++++++++++++++
 tb/tb_memory_access.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// Memory stage of the pipeline: issues one aligned data-memory request per load/store,
// extends load data for write-back, and reports misalignment or timeout of the last access.
package memory_access_pkg;
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  dest_reg;
    logic [31:0] pc;
  } control_signals_struct;
endpackage

module memory_access
  import memory_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_module_enable,
  input  logic [31:0]           alu_result,
  input  logic [31:0]           store_data,
  input  control_signals_struct control_signals,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_req_we,
  output logic [31:0]           dmem_req_addr,
  output logic [31:0]           dmem_req_wdata,
  output logic [3:0]            dmem_req_be,
  input  logic                  dmem_resp_valid,
  input  logic [31:0]           dmem_resp_data,
  output logic [31:0]           loaded_data,
  output logic [31:0]           alu_result_out,
  output control_signals_struct control_signals_out,
  output logic                  mem_done,
  output logic                  mem_busy,
  output logic                  misaligned_fault,
  output logic                  timeout_fault,
  output logic [1:0]            fsm_state
);

  // Handshake: a request transfers on a cycle where dmem_req_valid and dmem_req_ready are
  // both high; valid stays high with all request fields stable until then. A load response
  // is a single dmem_resp_valid beat, accepted only while waiting for it.

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  we_q, we_d;
  control_signals_struct ctrl_q, ctrl_d;
  logic [31:0]           loaded_q, loaded_d;
  logic                  mis_q, mis_d;
  logic                  to_q, to_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic        is_load, is_store, aligned, legal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] resp_shift, load_ext;

  // Decode of the instruction presented with the start pulse.
  always_comb begin
    is_load  = control_signals.opcode == OPC_LOAD;
    is_store = control_signals.opcode == OPC_STORE;
    case (control_signals.funct3)
      3'b000:  aligned = 1'b1;
      3'b100:  aligned = !is_store;
      3'b001:  aligned = !alu_result[0];
      3'b101:  aligned = !alu_result[0] && !is_store;
      3'b010:  aligned = alu_result[1:0] == 2'b00;
      default: aligned = 1'b0;
    endcase
    legal = (is_load || is_store) && aligned;
    case (control_signals.funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << alu_result[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << alu_result[1:0];
        st_wdata = {2{store_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = store_data;
      end
    endcase
  end

  // Lane select and extension of the response, driven by the captured access.
  always_comb begin
    resp_shift = dmem_resp_data >> {addr_q[1:0], 3'b000};
    case (ctrl_q.funct3)
      3'b000:  load_ext = {{24{resp_shift[7]}}, resp_shift[7:0]};
      3'b100:  load_ext = {24'b0, resp_shift[7:0]};
      3'b001:  load_ext = {{16{resp_shift[15]}}, resp_shift[15:0]};
      3'b101:  load_ext = {16'b0, resp_shift[15:0]};
      default: load_ext = dmem_resp_data;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
    ctrl_d   = ctrl_q;
    loaded_d = loaded_q;
    mis_d    = mis_q;
    to_d     = to_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (mem_module_enable) begin
          addr_d   = alu_result;
          ctrl_d   = control_signals;
          loaded_d = '0;
          mis_d    = 1'b0;
          to_d     = 1'b0;
          cnt_d    = '0;
          we_d     = is_store;
          be_d     = is_store ? st_be : 4'b1111;
          wdata_d  = is_store ? st_wdata : 32'b0;
          if (legal) begin
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
            mis_d   = is_load || is_store;
          end
        end
      end
      S_REQ: begin
        // A handshake in the last allowed cycle still completes the access.
        if (dmem_req_ready) begin
          state_d = we_q ? S_DONE : S_WAIT;
          cnt_d   = cnt_q + 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (dmem_resp_valid) begin
          state_d  = S_DONE;
          loaded_d = load_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      ctrl_q   <= '0;
      loaded_q <= '0;
      mis_q    <= 1'b0;
      to_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      ctrl_q   <= ctrl_d;
      loaded_q <= loaded_d;
      mis_q    <= mis_d;
      to_q     <= to_d;
      cnt_q    <= cnt_d;
    end
  end

  // Request fields read as zero whenever no request is outstanding.
  assign dmem_req_valid      = state_q == S_REQ;
  assign dmem_req_we         = dmem_req_valid && we_q;
  assign dmem_req_addr       = dmem_req_valid ? {addr_q[31:2], 2'b00} : 32'b0;
  assign dmem_req_wdata      = dmem_req_valid ? wdata_q : 32'b0;
  assign dmem_req_be         = dmem_req_valid ? be_q : 4'b0;
  assign loaded_data         = loaded_q;
  assign alu_result_out      = addr_q;
  assign control_signals_out = ctrl_q;
  assign mem_done            = state_q == S_DONE;
  assign mem_busy            = (state_q == S_REQ) || (state_q == S_WAIT);
  assign misaligned_fault    = mis_q;
  assign timeout_fault       = to_q;
  assign fsm_state           = state_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: a spec-level access model predicts request fields,
// latency and write-back results; a negedge compare process checks them every cycle.
module tb_memory_access;
  import memory_access_pkg::*;

  localparam int T = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  mem_module_enable;
  logic [31:0]           alu_result, store_data;
  control_signals_struct control_signals;
  logic                  dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0]           dmem_req_addr, dmem_req_wdata;
  logic [3:0]            dmem_req_be;
  logic                  dmem_resp_valid;
  logic [31:0]           dmem_resp_data, loaded_data, alu_result_out;
  control_signals_struct control_signals_out;
  logic                  mem_done, mem_busy, misaligned_fault, timeout_fault;
  logic [1:0]            fsm_state;

  memory_access #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .mem_module_enable(mem_module_enable),
    .alu_result(alu_result), .store_data(store_data), .control_signals(control_signals),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
    .loaded_data(loaded_data), .alu_result_out(alu_result_out),
    .control_signals_out(control_signals_out), .mem_done(mem_done), .mem_busy(mem_busy),
    .misaligned_fault(misaligned_fault), .timeout_fault(timeout_fault),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0]           loaded;
    logic                  mis;
    logic                  to;
    logic [31:0]           alu;
    control_signals_struct ctrl;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_cmp;
  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;
  logic        exp_rv = 1'b0, exp_busy = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_be = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- access model ----------------
  function automatic int m_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_legal(input bit is_st, input logic [2:0] f3, input logic [31:0] addr);
    int b;
    b = m_bytes(f3);
    if (b == 0) return 1'b0;
    if (f3[2] && (is_st || b == 4)) return 1'b0;
    return (addr % b) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int b;
    b = m_bytes(f3);
    return 4'(((1 << b) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] data);
    case (m_bytes(f3))
      1:       return (data % 256) * 32'h0101_0101;
      2:       return (data % 65536) * 32'h0001_0001;
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] data);
    longint unsigned lane;
    lane = longint'(data) / (64'd1 << (8 * (addr % 4)));
    case (f3)
      3'b000: begin
        lane = lane % 256;
        return (lane >= 128) ? 32'(lane + 64'hFFFF_FF00) : 32'(lane);
      end
      3'b100: return 32'(lane % 256);
      3'b001: begin
        lane = lane % 65536;
        return (lane >= 32768) ? 32'(lane + 64'hFFFF_0000) : 32'(lane);
      end
      3'b101: return 32'(lane % 65536);
      default: return data;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_valid", dmem_req_valid, exp_rv);
      check("mem_busy", mem_busy, exp_busy);
      if (dmem_req_valid) begin
        check("req_addr", dmem_req_addr, exp_addr);
        check("req_we", dmem_req_we, exp_we);
        check("req_be", dmem_req_be, exp_be);
        check("req_wdata", dmem_req_wdata, exp_wdata);
      end
      if (mem_done) begin
        check("done_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e_cmp = exp_q.pop_front();
          check("loaded_data", loaded_data, e_cmp.loaded);
          check("misaligned_fault", misaligned_fault, e_cmp.mis);
          check("timeout_fault", timeout_fault, e_cmp.to);
          check("alu_result_out", alu_result_out, e_cmp.alu);
          check("control_signals_out", control_signals_out, e_cmp.ctrl);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_all_zero(input string tag);
    check({tag, "_req_valid"}, dmem_req_valid, 0);
    check({tag, "_req_we"}, dmem_req_we, 0);
    check({tag, "_req_addr"}, dmem_req_addr, 0);
    check({tag, "_req_wdata"}, dmem_req_wdata, 0);
    check({tag, "_req_be"}, dmem_req_be, 0);
    check({tag, "_loaded"}, loaded_data, 0);
    check({tag, "_alu_out"}, alu_result_out, 0);
    check({tag, "_ctrl_out"}, control_signals_out, 0);
    check({tag, "_done"}, mem_done, 0);
    check({tag, "_busy"}, mem_busy, 0);
    check({tag, "_mis"}, misaligned_fault, 0);
    check({tag, "_to"}, timeout_fault, 0);
    check({tag, "_state"}, fsm_state, 0);
  endtask

  // rd: stall cycles before ready; respd: cycles after the first WAIT cycle before the response.
  task automatic run_access(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sdata, input int rd,
                            input int respd, input logic [31:0] rdata, input int exp_lat,
                            input bit poke);
    bit   is_ld, is_st, goes_req, to;
    int   lat, done_cyc;
    exp_t e;
    is_ld    = op == 7'b0000011;
    is_st    = op == 7'b0100011;
    goes_req = (is_ld || is_st) && m_legal(is_st, f3, addr);
    to       = 1'b0;
    if (!goes_req) lat = 1;
    else if (rd >= T) begin lat = T + 1; to = 1'b1; end
    else if (is_st) lat = 2 + rd;
    else if (2 + rd + respd > T) begin lat = T + 1; to = 1'b1; end
    else lat = 3 + rd + respd;
    check({name, "_model_lat"}, lat, exp_lat);

    control_signals = '{opcode: op, funct3: f3, dest_reg: 5'($urandom_range(0, 31)),
                        pc: $urandom()};
    e.loaded = (goes_req && is_ld && !to) ? m_load(f3, addr, rdata) : 32'b0;
    e.mis    = (is_ld || is_st) && !goes_req;
    e.to     = to;
    e.alu    = addr;
    e.ctrl   = control_signals;
    exp_q.push_back(e);
    exp_addr  = {addr[31:2], 2'b00};
    exp_we    = is_st;
    exp_be    = is_st ? m_be(f3, addr) : 4'b1111;
    exp_wdata = is_st ? m_wdata(f3, sdata) : 32'b0;

    alu_result        = addr;
    store_data        = sdata;
    mem_module_enable = 1'b1;
    dmem_req_ready    = 1'b0;
    dmem_resp_valid   = 1'b0;
    exp_rv            = 1'b0;
    exp_busy          = 1'b0;
    done_cyc          = -1;
    for (int c = 1; c <= T + 4 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      mem_module_enable = poke && c == 1;
      if (poke && c == 1) begin
        alu_result      = 32'hDEAD_BEEF;
        control_signals = '{opcode: 7'b0000011, funct3: 3'b010, dest_reg: 5'd1, pc: 32'h4};
      end
      dmem_req_ready  = c == 1 + rd;
      dmem_resp_valid = is_ld && c == 2 + rd + respd;
      dmem_resp_data  = (c == 2 + rd + respd) ? rdata : $urandom();
      exp_busy        = goes_req && c < lat;
      exp_rv          = goes_req && c <= 1 + rd && c < lat;
      @(negedge clk);
      if (mem_done) done_cyc = c;
    end
    check({name, "_latency"}, done_cyc, exp_lat);
    @(posedge clk); #1;
    mem_module_enable = 1'b0;
    dmem_req_ready    = 1'b0;
    dmem_resp_valid   = 1'b0;
    exp_rv            = 1'b0;
    exp_busy          = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset             = 1'b1;
    mem_module_enable = 1'b0;
    alu_result        = '0;
    store_data        = '0;
    control_signals   = '0;
    dmem_req_ready    = 1'b0;
    dmem_resp_valid   = 1'b0;
    dmem_resp_data    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Hand-computed pins on the model.
    check("pin_lb_ext", m_load(3'b000, 32'h1003, 32'h80FF_FF00), 32'hFFFF_FF80);
    check("pin_sh_be", m_be(3'b001, 32'h2002), 4'b1100);
    check("pin_sh_wdata", m_wdata(3'b001, 32'h0000_ABCD), 32'hABCD_ABCD);
    check("pin_lh_ext", m_load(3'b001, 32'h6002, 32'h8001_1234), 32'hFFFF_8001);

    run_access("lb", 7'b0000011, 3'b000, 32'h1003, 32'h0, 0, 0, 32'h80FF_FF00, 3, 0);
    check("lb_loaded_lit", loaded_data, 32'hFFFF_FF80);
    run_access("sh", 7'b0100011, 3'b001, 32'h2002, 32'h0000_ABCD, 2, 0, 32'h0, 4, 0);
    run_access("lw_mis", 7'b0000011, 3'b010, 32'h3001, 32'h0, 0, 0, 32'h0, 1, 0);
    check("lw_mis_lit", misaligned_fault, 1);
    run_access("add", 7'b0110011, 3'b000, 32'h55, 32'h0, 0, 0, 32'h0, 1, 0);
    check("add_alu_lit", alu_result_out, 32'h55);
    run_access("lhu_to", 7'b0000011, 3'b101, 32'h4002, 32'h0, 0, 100, 32'h0, T + 1, 0);
    check("lhu_to_lit", timeout_fault, 1);
    dmem_resp_valid = 1'b1;
    dmem_resp_data  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    check("late_resp_loaded", loaded_data, 0);
    check("late_resp_to", timeout_fault, 1);
    check("late_resp_state", fsm_state, 0);

    run_access("lh", 7'b0000011, 3'b001, 32'h6002, 32'h0, 1, 1, 32'h8001_1234, 5, 0);
    run_access("lbu", 7'b0000011, 3'b100, 32'h7001, 32'h0, 0, 2, 32'h0000_9A00, 5, 0);
    run_access("sb", 7'b0100011, 3'b000, 32'h8003, 32'h0000_0077, 0, 0, 32'h0, 2, 0);
    run_access("sw_edge", 7'b0100011, 3'b010, 32'h9000, 32'h1234_5678, T - 1, 0, 32'h0, T + 1, 0);
    check("sw_edge_to", timeout_fault, 0);
    run_access("lw_edge", 7'b0000011, 3'b010, 32'hA000, 32'h0, 0, T - 2, 32'hCAFE_F00D, T + 1, 0);
    run_access("sw_to", 7'b0100011, 3'b010, 32'hA100, 32'h1111_2222, T, 0, 32'h0, T + 1, 0);
    run_access("lh_mis", 7'b0000011, 3'b001, 32'hB001, 32'h0, 0, 0, 32'h0, 1, 0);
    run_access("st_f3_bad", 7'b0100011, 3'b100, 32'hB004, 32'h0, 0, 0, 32'h0, 1, 0);
    run_access("ld_f3_bad", 7'b0000011, 3'b011, 32'hB008, 32'h0, 0, 0, 32'h0, 1, 0);
    run_access("poke", 7'b0000011, 3'b010, 32'hC004, 32'h0, 1, 0, 32'h0BAD_F00D, 4, 1);

    // Reset in WAIT alongside a response and a start pulse.
    control_signals   = '{opcode: 7'b0000011, funct3: 3'b010, dest_reg: 5'd3, pc: 32'h100};
    alu_result        = 32'h5000;
    mem_module_enable = 1'b1;
    exp_addr          = 32'h5000;
    exp_we            = 1'b0;
    exp_be            = 4'b1111;
    exp_wdata         = 32'b0;
    @(posedge clk); #1;
    mem_module_enable = 1'b0;
    dmem_req_ready    = 1'b1;
    exp_rv            = 1'b1;
    exp_busy          = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready    = 1'b0;
    exp_rv            = 1'b0;
    reset             = 1'b1;
    dmem_resp_valid   = 1'b1;
    dmem_resp_data    = 32'h1234_5678;
    mem_module_enable = 1'b1;
    @(posedge clk); #1;
    reset             = 1'b0;
    dmem_resp_valid   = 1'b0;
    mem_module_enable = 1'b0;
    exp_busy          = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
